// File: rtl/regfile_port_arbiter.sv
// Two-requester port arbiter for the register file: round-robin with a bounded burst lock.
// Define REGFILE_ARB_STATS_EN to add grant counters and a starvation high-water mark.
module regfile_port_arbiter #(
    parameter int unsigned NREGS     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_rd,
    input  logic [AW-1:0]    m0_rs1,
    input  logic [AW-1:0]    m0_rs2,
    input  logic [DW-1:0]    m0_wdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_rd,
    input  logic [AW-1:0]    m1_rs1,
    input  logic [AW-1:0]    m1_rs2,
    input  logic [DW-1:0]    m1_wdata,
    output logic             m0_ack,
    output logic             m1_ack,
    output logic [NREGS-1:0] reg_load,
    output logic [NREGS-1:0] reg_out0_en,
    output logic [NREGS-1:0] reg_out1_en,
    output logic [DW-1:0]    reg_data_in
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]      m0_gnt_cnt,
    output logic [15:0]      m1_gnt_cnt,
    output logic [7:0]       starve_max
`endif
);

    localparam int unsigned CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CW-1:0] BurstLast = CW'(BURST_MAX - 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e        state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic [CW-1:0] burst_q, burst_d;
    logic [CW-1:0] burst_inc;

    // Out-of-range addresses decode to an all-zero vector.
    function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] addr);
        logic [NREGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(addr) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign burst_inc = (burst_q == BurstLast) ? burst_q : burst_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        burst_d   = burst_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req && m1_req) state_d = rr_last_q ? StOwn0 : StOwn1;
                else if (m0_req)      state_d = StOwn0;
                else if (m1_req)      state_d = StOwn1;
            end
            StOwn0: begin
                if (!m0_req || (m1_req && burst_q == BurstLast)) begin
                    state_d   = m1_req ? StOwn1 : StIdle;
                    rr_last_d = 1'b0;
                    burst_d   = '0;
                end else begin
                    burst_d = burst_inc;
                end
            end
            StOwn1: begin
                if (!m1_req || (m0_req && burst_q == BurstLast)) begin
                    state_d   = m0_req ? StOwn0 : StIdle;
                    rr_last_d = 1'b1;
                    burst_d   = '0;
                end else begin
                    burst_d = burst_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            rr_last_q <= 1'b1;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            burst_q   <= burst_d;
        end
    end

    // Gating with reset_n keeps strobes dead for the whole reset pulse, not just after the flop.
    always_comb begin
        m0_ack      = reset_n && (state_q == StOwn0) && m0_req;
        m1_ack      = reset_n && (state_q == StOwn1) && m1_req;
        reg_load    = '0;
        reg_out0_en = '0;
        reg_out1_en = '0;
        reg_data_in = '0;
        if (m0_ack) begin
            reg_load    = m0_we ? onehot(m0_rd) : '0;
            reg_out0_en = onehot(m0_rs1);
            reg_out1_en = onehot(m0_rs2);
            reg_data_in = m0_wdata;
        end else if (m1_ack) begin
            reg_load    = m1_we ? onehot(m1_rd) : '0;
            reg_out0_en = onehot(m1_rs1);
            reg_out1_en = onehot(m1_rs2);
            reg_data_in = m1_wdata;
        end
        reg_load[0] = 1'b0;
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic [7:0]  run0_q, run0_d, run1_q, run1_d, starve_q, starve_d;

    // A starvation run grows only while the other side is actually being served.
    function automatic logic [7:0] run_next(input logic [7:0] run, input logic req,
                                            input logic ack, input logic other_ack);
        if (!req || ack)                 return 8'd0;
        else if (other_ack && run != 8'hFF) return run + 8'd1;
        else                             return run;
    endfunction

    always_comb begin
        m0_gnt_d = m0_gnt_q + 16'(m0_ack);
        m1_gnt_d = m1_gnt_q + 16'(m1_ack);
        run0_d   = run_next(run0_q, m0_req, m0_ack, m1_ack);
        run1_d   = run_next(run1_q, m1_req, m1_ack, m0_ack);
        starve_d = starve_q;
        if (run0_d > starve_d) starve_d = run0_d;
        if (run1_d > starve_d) starve_d = run1_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_gnt_q <= '0;
            m1_gnt_q <= '0;
            run0_q   <= '0;
            run1_q   <= '0;
            starve_q <= '0;
        end else begin
            m0_gnt_q <= m0_gnt_d;
            m1_gnt_q <= m1_gnt_d;
            run0_q   <= run0_d;
            run1_q   <= run1_d;
            starve_q <= starve_d;
        end
    end

    assign m0_gnt_cnt = m0_gnt_q;
    assign m1_gnt_cnt = m1_gnt_q;
    assign starve_max = starve_q;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: vector table, corner sequences, randomized
// traffic against a cycle model of the arbitration rules.
module tb_regfile_port_arbiter;

    localparam int unsigned NREGS     = 32;
    localparam int unsigned AW        = 5;
    localparam int unsigned DW        = 32;
    localparam int unsigned BURST_MAX = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_rd, m0_rs1, m0_rs2, m1_rd, m1_rs1, m1_rs2;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic m0_ack, m1_ack;
    logic [NREGS-1:0] reg_load, reg_out0_en, reg_out1_en;
    logic [DW-1:0] reg_data_in;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] m0_gnt_cnt, m1_gnt_cnt;
    logic [7:0]  starve_max;
`endif

    int total = 0;
    int bad = 0;

    // Arbitration model: owner (-1 none, 0, 1), last owner served, acked cycles in current run.
    int m_owner, m_last, m_run;

    logic [DW-1:0] rf [NREGS];

    regfile_port_arbiter #(
        .NREGS(NREGS), .AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_rd(m0_rd), .m0_rs1(m0_rs1), .m0_rs2(m0_rs2),
        .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_rd(m1_rd), .m1_rs1(m1_rs1), .m1_rs2(m1_rs2),
        .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .reg_load(reg_load), .reg_out0_en(reg_out0_en), .reg_out1_en(reg_out1_en),
        .reg_data_in(reg_data_in)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt), .starve_max(starve_max)
`endif
    );

    always #5 clk = ~clk;

    // Register file stand-in: loads on the falling edge like the real register32bit cells.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) if (reg_load[i]) rf[i] <= reg_data_in;
        end
    end

    typedef struct {
        logic r0; logic w0; logic [4:0] rd0; logic [4:0] a0; logic [4:0] b0; logic [31:0] d0;
        logic r1; logic w1; logic [4:0] rd1; logic [4:0] a1; logic [4:0] b1; logic [31:0] d1;
        logic ea0; logic ea1;
        logic [31:0] eld; logic [31:0] eo0; logic [31:0] eo1; logic [31:0] ed;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [4:0] rd, input logic [4:0] a,
                          input logic [4:0] b, input logic [31:0] d);
        m0_req = r; m0_we = w; m0_rd = rd; m0_rs1 = a; m0_rs2 = b; m0_wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [4:0] rd, input logic [4:0] a,
                          input logic [4:0] b, input logic [31:0] d);
        m1_req = r; m1_we = w; m1_rd = rd; m1_rs1 = a; m1_rs2 = b; m1_wdata = d;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_run   = 0;
    endtask

    task automatic do_reset();
        set_m0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_m1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic model_expect(output logic a0, output logic a1, output logic [31:0] ld,
                                output logic [31:0] o0, output logic [31:0] o1,
                                output logic [31:0] dt);
        a0 = (m_owner == 0) && m0_req;
        a1 = (m_owner == 1) && m1_req;
        ld = 32'd0; o0 = 32'd0; o1 = 32'd0; dt = 32'd0;
        if (a0) begin
            o0 = 32'd1 << m0_rs1;
            o1 = 32'd1 << m0_rs2;
            ld = (m0_we && m0_rd != 5'd0) ? (32'd1 << m0_rd) : 32'd0;
            dt = m0_wdata;
        end else if (a1) begin
            o0 = 32'd1 << m1_rs1;
            o1 = 32'd1 << m1_rs2;
            ld = (m1_we && m1_rd != 5'd0) ? (32'd1 << m1_rd) : 32'd0;
            dt = m1_wdata;
        end
    endtask

    task automatic model_step(input logic q0, input logic q1);
        logic qx, qy;
        if (m_owner < 0) begin
            if (q0 && q1)  m_owner = 1 - m_last;
            else if (q0)   m_owner = 0;
            else if (q1)   m_owner = 1;
            m_run = 0;
        end else begin
            qx = (m_owner == 0) ? q0 : q1;
            qy = (m_owner == 0) ? q1 : q0;
            if (qx) m_run++;
            if (!qx || (qy && m_run >= BURST_MAX)) begin
                m_last  = m_owner;
                m_owner = qy ? 1 - m_owner : -1;
                m_run   = 0;
            end
        end
    endtask

    task automatic cycle_model(input string tag);
        logic ea0, ea1;
        logic [31:0] eld, eo0, eo1, ed;
        #2;
        model_expect(ea0, ea1, eld, eo0, eo1, ed);
        check({tag, "_ack0"}, 64'(m0_ack), 64'(ea0));
        check({tag, "_ack1"}, 64'(m1_ack), 64'(ea1));
        check({tag, "_load"}, 64'(reg_load), 64'(eld));
        check({tag, "_out0"}, 64'(reg_out0_en), 64'(eo0));
        check({tag, "_out1"}, 64'(reg_out1_en), 64'(eo1));
        check({tag, "_data"}, 64'(reg_data_in), 64'(ed));
        model_step(m0_req, m1_req);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e0, e1;
        int p0, p1;

        vecs[0] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd3, 32'hDEADBEEF,
                    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd3, 32'hDEADBEEF,
                    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b1, 1'b0, 32'h20, 32'h20, 32'h8, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h11111111,
                    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b1, 1'b0, 32'h0, 32'h20, 32'h1, 32'h11111111};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b1, 1'b1, 5'd0, 5'd31, 5'd2, 32'hFFFFFFFF,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b1, 1'b1, 5'd0, 5'd31, 5'd2, 32'hFFFFFFFF,
                    1'b0, 1'b1, 32'h0, 32'h80000000, 32'h4, 32'hFFFFFFFF};
        vecs[5] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b1, 1'b1, 5'd31, 5'd0, 5'd31, 32'h12345678,
                    1'b0, 1'b1, 32'h80000000, 32'h1, 32'h80000000, 32'h12345678};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 5'd7, 5'd1, 5'd2, 32'hA5A5A5A5,
                    1'b1, 1'b1, 5'd9, 5'd3, 5'd4, 32'h5A5A5A5A,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[8] = '{1'b1, 1'b1, 5'd7, 5'd1, 5'd2, 32'hA5A5A5A5,
                    1'b1, 1'b1, 5'd9, 5'd3, 5'd4, 32'h5A5A5A5A,
                    1'b1, 1'b0, 32'h80, 32'h2, 32'h4, 32'hA5A5A5A5};
        vecs[9] = vecs[8];

        // Directed table from reset: write/read, rd=0 discard, handover, return to idle, tie.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_m0(vecs[i].r0, vecs[i].w0, vecs[i].rd0, vecs[i].a0, vecs[i].b0, vecs[i].d0);
            set_m1(vecs[i].r1, vecs[i].w1, vecs[i].rd1, vecs[i].a1, vecs[i].b1, vecs[i].d1);
            #2;
            check($sformatf("vec%0d_ack0", i), 64'(m0_ack), 64'(vecs[i].ea0));
            check($sformatf("vec%0d_ack1", i), 64'(m1_ack), 64'(vecs[i].ea1));
            check($sformatf("vec%0d_load", i), 64'(reg_load), 64'(vecs[i].eld));
            check($sformatf("vec%0d_out0", i), 64'(reg_out0_en), 64'(vecs[i].eo0));
            check($sformatf("vec%0d_out1", i), 64'(reg_out1_en), 64'(vecs[i].eo1));
            check($sformatf("vec%0d_data", i), 64'(reg_data_in), 64'(vecs[i].ed));
            @(posedge clk);
            #1;
        end
        check("rf5_written", 64'(rf[5]), 64'(32'hDEADBEEF));
        check("rf0_stays_zero", 64'(rf[0]), 64'(32'h0));
        check("rf31_written", 64'(rf[31]), 64'(32'h12345678));

        // Contention from reset: one idle cycle, then runs of BURST_MAX alternating from m0.
        do_reset();
        set_m0(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0);
        set_m1(1'b1, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0);
        for (int k = 0; k < 17; k++) begin
            #2;
            e0 = (k >= 1) && (((k - 1) / BURST_MAX) % 2 == 0);
            e1 = (k >= 1) && !e0;
            check($sformatf("rr%0d_ack0", k), 64'(m0_ack), 64'(e0));
            check($sformatf("rr%0d_ack1", k), 64'(m1_ack), 64'(e1));
            @(posedge clk);
            #1;
        end
`ifdef REGFILE_ARB_STATS_EN
        check("stats_m0_gnt", 64'(m0_gnt_cnt), 64'd8);
        check("stats_m1_gnt", 64'(m1_gnt_cnt), 64'd8);
        check("stats_starve", 64'(starve_max), 64'd4);
`endif

        // Lone requester keeps the port; a late second request is served on the next cycle.
        do_reset();
        set_m0(1'b1, 1'b0, 5'd0, 5'd6, 5'd7, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k == 6) set_m1(1'b1, 1'b0, 5'd0, 5'd8, 5'd9, 32'h0);
            #2;
            e0 = (k >= 1) && (k <= 6);
            e1 = (k >= 7);
            check($sformatf("solo%0d_ack0", k), 64'(m0_ack), 64'(e0));
            check($sformatf("solo%0d_ack1", k), 64'(m1_ack), 64'(e1));
            @(posedge clk);
            #1;
        end

        // Reset dropped between edges mid-burst: everything dies at once; m0 wins the next tie.
        do_reset();
        set_m0(1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 32'hCAFEF00D);
        set_m1(1'b1, 1'b1, 5'd6, 5'd6, 5'd6, 32'h0BADF00D);
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("pre%0d_ack0", k), 64'(m0_ack), 64'(k >= 1));
            @(posedge clk);
            #1;
        end
        #2;
        check("pre_rst_load", 64'(reg_load), 64'(32'h10));
        reset_n = 1'b0;
        #1;
        check("rst_ack0", 64'(m0_ack), 64'd0);
        check("rst_ack1", 64'(m1_ack), 64'd0);
        check("rst_load", 64'(reg_load), 64'd0);
        check("rst_out0", 64'(reg_out0_en), 64'd0);
        check("rst_out1", 64'(reg_out1_en), 64'd0);
        check("rst_data", 64'(reg_data_in), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #2;
        check("post_rst_idle_ack0", 64'(m0_ack), 64'd0);
        check("post_rst_idle_ack1", 64'(m1_ack), 64'd0);
        @(posedge clk);
        #1;
        #2;
        check("post_rst_tie_ack0", 64'(m0_ack), 64'd1);
        check("post_rst_tie_ack1", 64'(m1_ack), 64'd0);

        // Randomized traffic in phases of differing request pressure.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            case (c / 150)
                0:       begin p0 = 90; p1 = 90; end
                1:       begin p0 = 50; p1 = 50; end
                2:       begin p0 = 95; p1 = 10; end
                default: begin p0 = 20; p1 = 80; end
            endcase
            set_m0(1'($urandom_range(0, 99) < p0), 1'($urandom()), 5'($urandom()),
                   5'($urandom()), 5'($urandom()), $urandom());
            set_m1(1'($urandom_range(0, 99) < p1), 1'($urandom()), 5'($urandom()),
                   5'($urandom()), 5'($urandom()), $urandom());
            cycle_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
